branch_redirect_controller: RTL and testbench

Sequences front-end recovery when the branch predictor's guess is proven wrong in ID. Captures the resolved branch target, drives a registered redirect to the IF PC mux, and holds the redirect until fetch accepts it. Squashes wrong-path fetch slots for a configurable refill window and keeps saturating branch/mispredict statistics. Sits between the ID-stage resolution logic, the branch predictor's prediction_failed output and the IF PC register.

---
 rtl/branch_redirect_controller.sv | 156 +++++++++++++++
 tb/tb_branch_redirect_controller.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_controller.sv
// -----------------------------------------------------------------------------
// branch_redirect_controller
//
// Sequences front-end recovery after ID proves a branch prediction wrong.
// The resolved target is captured and presented to the IF PC mux as a
// registered redirect. The redirect is held until fetch accepts it. A
// configurable number of refill cycles then squashes wrong-path fetch
// slots. Saturating branch and mispredict statistics are kept.
//
// Ports
//   clk                  rising-edge clock
//   rst                  asynchronous reset, active-low (0 = reset)
//   id_valid             ID holds a valid instruction
//   id_is_branch         ID instruction is a conditional branch or jump
//   id_prediction_failed predicted PC differs from the resolved target
//   id_correct_pc        resolved next PC from ID
//   hazard_stall         ID is held; the same instruction will re-present
//   if_stall             IF cannot accept a redirect this cycle
//   redirect_valid       IF must load redirect_pc
//   redirect_pc          captured correct target
//   flush_if             squash the instruction in the IF/ID register
//   busy                 controller is not idle
//   branch_count         accepted branches, saturating
//   mispredict_count     accepted mispredictions, saturating
// -----------------------------------------------------------------------------
module branch_redirect_controller #(
    parameter int XLEN          = 64,
    parameter int REFILL_CYCLES = 1,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_is_branch,
    input  logic             id_prediction_failed,
    input  logic [XLEN-1:0]  id_correct_pc,
    input  logic             hazard_stall,
    input  logic             if_stall,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush_if,
    output logic             busy,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        REFILL   = 2'd2
    } state_e;

    // The refill counter only ever holds values up to REFILL_CYCLES-1.
    localparam int RC_W = (REFILL_CYCLES < 2) ? 1 : $clog2(REFILL_CYCLES);
    localparam logic [RC_W-1:0] REFILL_LOAD =
        RC_W'((REFILL_CYCLES > 0) ? (REFILL_CYCLES - 1) : 0);

    state_e            state_q, state_d;
    logic [RC_W-1:0]   refill_cnt_q, refill_cnt_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic              flush_if_q, flush_if_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  branch_count_q, branch_count_d;
    logic [CNT_W-1:0]  mispredict_count_q, mispredict_count_d;
    logic              acc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // A hazard-held instruction re-presents, so it is only taken on its
    // non-stalled cycle; this makes every branch count exactly once.
    assign acc = id_valid & id_is_branch & ~hazard_stall;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d            = state_q;
        refill_cnt_d       = refill_cnt_q;
        redirect_pc_d      = redirect_pc_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;

        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    branch_count_d = sat_inc(branch_count_q);
                    if (id_prediction_failed) begin
                        mispredict_count_d = sat_inc(mispredict_count_q);
                        redirect_pc_d      = id_correct_pc;
                        state_d            = REDIRECT;
                    end
                end
            end
            REDIRECT: begin
                // ID inputs are wrong-path here; only fetch acceptance matters.
                if (!if_stall) begin
                    if (REFILL_CYCLES > 0) begin
                        state_d      = REFILL;
                        refill_cnt_d = REFILL_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            REFILL: begin
                // Countdown runs regardless of if_stall.
                if (refill_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    refill_cnt_d = refill_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they leave flops
        // alongside the state itself.
        redirect_valid_d = (state_d == REDIRECT);
        flush_if_d       = (state_d != IDLE);
        busy_d           = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q            <= IDLE;
            refill_cnt_q       <= '0;
            redirect_pc_q      <= '0;
            redirect_valid_q   <= 1'b0;
            flush_if_q         <= 1'b0;
            busy_q             <= 1'b0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            state_q            <= state_d;
            refill_cnt_q       <= refill_cnt_d;
            redirect_pc_q      <= redirect_pc_d;
            redirect_valid_q   <= redirect_valid_d;
            flush_if_q         <= flush_if_d;
            busy_q             <= busy_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign redirect_valid   = redirect_valid_q;
    assign redirect_pc      = redirect_pc_q;
    assign flush_if         = flush_if_q;
    assign busy             = busy_q;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_redirect_controller.sv
// -----------------------------------------------------------------------------
// Bench for branch_redirect_controller. Three instances share one stimulus
// stream: d0 (refill 1, 32-bit counters), d1 (refill 0, 4-bit counters) and
// d2 (refill 3, 32-bit counters). A behavioural model per instance tracks
// "redirect pending" and "squash cycles left" and is compared every cycle.
// -----------------------------------------------------------------------------
module tb_branch_redirect_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic        id_is_branch = 1'b0;
    logic        id_prediction_failed = 1'b0;
    logic [63:0] id_correct_pc = '0;
    logic        hazard_stall = 1'b0;
    logic        if_stall = 1'b0;

    logic        rv_o  [3];
    logic [63:0] pc_o  [3];
    logic        fl_o  [3];
    logic        bsy_o [3];
    logic [31:0] bc0, mc0, bc2, mc2;
    logic [3:0]  bc1, mc1;

    int n_checks = 0;
    int n_errors = 0;

    // Model state per instance.
    int          refill_of [3] = '{1, 0, 3};
    longint      cnt_max   [3] = '{64'hFFFF_FFFF, 64'd15, 64'hFFFF_FFFF};
    bit          m_rv   [3];
    logic [63:0] m_pc   [3];
    longint      m_bc   [3];
    longint      m_mc   [3];
    int          m_left [3];

    always #5 clk = ~clk;

    branch_redirect_controller #(.XLEN(64), .REFILL_CYCLES(1), .CNT_W(32)) d0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_is_branch(id_is_branch),
        .id_prediction_failed(id_prediction_failed), .id_correct_pc(id_correct_pc),
        .hazard_stall(hazard_stall), .if_stall(if_stall),
        .redirect_valid(rv_o[0]), .redirect_pc(pc_o[0]), .flush_if(fl_o[0]),
        .busy(bsy_o[0]), .branch_count(bc0), .mispredict_count(mc0));

    branch_redirect_controller #(.XLEN(64), .REFILL_CYCLES(0), .CNT_W(4)) d1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_is_branch(id_is_branch),
        .id_prediction_failed(id_prediction_failed), .id_correct_pc(id_correct_pc),
        .hazard_stall(hazard_stall), .if_stall(if_stall),
        .redirect_valid(rv_o[1]), .redirect_pc(pc_o[1]), .flush_if(fl_o[1]),
        .busy(bsy_o[1]), .branch_count(bc1), .mispredict_count(mc1));

    branch_redirect_controller #(.XLEN(64), .REFILL_CYCLES(3), .CNT_W(32)) d2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_is_branch(id_is_branch),
        .id_prediction_failed(id_prediction_failed), .id_correct_pc(id_correct_pc),
        .hazard_stall(hazard_stall), .if_stall(if_stall),
        .redirect_valid(rv_o[2]), .redirect_pc(pc_o[2]), .flush_if(fl_o[2]),
        .busy(bsy_o[2]), .branch_count(bc2), .mispredict_count(mc2));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_rv[i] = 1'b0; m_pc[i] = '0; m_bc[i] = 0; m_mc[i] = 0; m_left[i] = 0;
        end
    endtask

    // One clock edge of the specified behaviour, using the inputs held there.
    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            if (m_rv[i]) begin
                if (!if_stall) begin
                    m_rv[i]   = 1'b0;
                    m_left[i] = refill_of[i];
                end
            end else if (m_left[i] > 0) begin
                m_left[i]--;
            end else if (id_valid && id_is_branch && !hazard_stall) begin
                if (m_bc[i] < cnt_max[i]) m_bc[i]++;
                if (id_prediction_failed) begin
                    if (m_mc[i] < cnt_max[i]) m_mc[i]++;
                    m_pc[i] = id_correct_pc;
                    m_rv[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [63:0] bc [3];
        logic [63:0] mc [3];
        bit          sq;
        bc[0] = 64'(bc0); bc[1] = 64'(bc1); bc[2] = 64'(bc2);
        mc[0] = 64'(mc0); mc[1] = 64'(mc1); mc[2] = 64'(mc2);
        for (int i = 0; i < 3; i++) begin
            sq = m_rv[i] || (m_left[i] > 0);
            check($sformatf("d%0d_redirect_valid", i), 64'(rv_o[i]), 64'(m_rv[i]));
            check($sformatf("d%0d_redirect_pc", i), pc_o[i], m_pc[i]);
            check($sformatf("d%0d_flush_if", i), 64'(fl_o[i]), 64'(sq));
            check($sformatf("d%0d_busy", i), 64'(bsy_o[i]), 64'(sq));
            check($sformatf("d%0d_branch_count", i), bc[i], 64'(m_bc[i]));
            check($sformatf("d%0d_mispredict_count", i), mc[i], 64'(m_mc[i]));
        end
    endtask

    // Drive one cycle of inputs, advance one edge, then compare.
    task automatic step(input bit v, input bit br, input bit pf, input logic [63:0] pc,
                        input bit hz, input bit fs);
        id_valid = v; id_is_branch = br; id_prediction_failed = pf;
        id_correct_pc = pc; hazard_stall = hz; if_stall = fs;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, '0, 0, 0);
    endtask

    initial begin
        longint bc_before, mc_before;

        // Reset state.
        model_reset();
        #1 rst = 1'b0;
        #1;
        check("reset_rv", 64'(rv_o[0]), 64'd0);
        check("reset_pc", pc_o[0], 64'd0);
        compare_all();
        @(negedge clk);
        rst = 1'b1;

        // Single mispredict to 0x1000 with fetch ready.
        step(1, 1, 1, 64'h1000, 0, 0);
        check("single_T1_rv", 64'(rv_o[0]), 64'd1);
        check("single_T1_pc", pc_o[0], 64'h1000);
        check("single_T1_flush", 64'(fl_o[0]), 64'd1);
        step(0, 0, 0, '0, 0, 0);
        check("single_T2_rv", 64'(rv_o[0]), 64'd0);
        check("single_T2_flush", 64'(fl_o[0]), 64'd1);
        step(0, 0, 0, '0, 0, 0);
        check("single_T3_busy", 64'(bsy_o[0]), 64'd0);
        check("single_bc", 64'(bc0), 64'd1);
        check("single_mc", 64'(mc0), 64'd1);
        idle(4);

        // Fetch stall holds the redirect for 4 cycles.
        step(1, 1, 1, 64'h2040, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, '0, 0, 1);
            check("stall_rv_held", 64'(rv_o[0]), 64'd1);
            check("stall_pc_held", pc_o[0], 64'h2040);
        end
        step(0, 0, 0, '0, 0, 0);
        check("stall_refill_rv", 64'(rv_o[0]), 64'd0);
        check("stall_refill_flush", 64'(fl_o[0]), 64'd1);
        idle(5);

        // Hazard-held correctly predicted branch counts once.
        bc_before = longint'(bc0);
        mc_before = longint'(mc0);
        for (int k = 0; k < 3; k++) step(1, 1, 0, 64'h7777, 1, 0);
        step(1, 1, 0, 64'h7777, 0, 0);
        idle(1);
        check("hazard_bc", 64'(bc0), 64'(bc_before + 1));
        check("hazard_mc", 64'(mc0), 64'(mc_before));

        // Wrong-path suppression, then capture on the first IDLE cycle.
        idle(4);
        bc_before = longint'(bc0);
        step(1, 1, 1, 64'h3000, 0, 0);
        step(1, 1, 1, 64'h4000, 0, 0);
        step(1, 1, 1, 64'h4000, 0, 0);
        check("wrongpath_pc", pc_o[0], 64'h3000);
        check("wrongpath_bc", 64'(bc0), 64'(bc_before + 1));
        step(1, 1, 1, 64'h5000, 0, 0);
        check("backtoback_rv", 64'(rv_o[0]), 64'd1);
        check("backtoback_pc", pc_o[0], 64'h5000);
        idle(6);

        // Reset mid-REDIRECT is immediate.
        step(1, 1, 1, 64'h8000, 0, 0);
        step(0, 0, 0, '0, 0, 1);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("midreset_rv", 64'(rv_o[0]), 64'd0);
        check("midreset_flush", 64'(fl_o[0]), 64'd0);
        check("midreset_busy", 64'(bsy_o[0]), 64'd0);
        check("midreset_mc", 64'(mc0), 64'd0);
        compare_all();
        @(negedge clk);
        rst = 1'b1;

        // Saturation on the 4-bit instance (refill 0).
        for (int k = 0; k < 60; k++) step(1, 1, 1, 64'(k) << 4, 0, 0);
        check("sat_bc", 64'(bc1), 64'd15);
        check("sat_mc", 64'(mc1), 64'd15);
        idle(5);

        // REFILL_CYCLES=0: redirect lasts one cycle, then idle.
        step(1, 1, 1, 64'h6000, 0, 0);
        check("norefill_rv", 64'(rv_o[1]), 64'd1);
        step(0, 0, 0, '0, 0, 0);
        check("norefill_busy", 64'(bsy_o[1]), 64'd0);
        check("norefill_flush", 64'(fl_o[1]), 64'd0);
        idle(5);

        // Randomized traffic against the model.
        for (int k = 0; k < 500; k++) begin
            step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 2) == 1,
                 {$urandom, $urandom}, ($urandom % 4) == 0, ($urandom % 10) < 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
